mm_seq_ctrl: RTL and testbench
==============================

// Module: mm_seq_ctrl
// PURPOSE
//  Sequencer for the streaming matrix-multiply datapath.
//  - Load: counts the incoming A and B elements, writes them into the operand buffers and captures both shapes from col_end/row_end.
//  - Legality: checks that A cols equals B rows.
//  - Compute: drives buffer read addresses and MAC controls for every C[i][j].
//  - Output: frames each result with out_valid / is_legal / change_row. Sits between the MM top-level stream ports and the buffer+MAC datapath.
// PARAMETERS
//  DIM_W    4  width of a dimension; max rows/cols = 2**DIM_W-1
//  ADDR_W   8  operand buffer address width; must be >= 2*DIM_W
//  MAC_LAT  1  cycles from rd_addr_* issue to operand at MAC input (>=1)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        element beat present this cycle
//  col_end    in   1        beat is last element of a row
//  row_end    in   1        beat is last element of the matrix (implies col_end)
//  busy       out  1        1: beats are ignored
//  wr_en      out  1        buffer write strobe (combinational from in_valid & ~busy)
//  wr_sel     out  1        0 = A buffer, 1 = B buffer
//  wr_addr    out  ADDR_W   row-major element index within the selected matrix
//  rd_addr_a  out  ADDR_W   A read address = i*a_cols+k
//  rd_addr_b  out  ADDR_W   B read address = k*b_cols+j
//  mac_clr    out  1        first product of a dot product (load, do not add)
//  mac_en     out  1        accumulate product at MAC input
//  mac_last   out  1        last product of current dot product
//  res_load   out  1        capture accumulator into output register
//  out_valid  out  1        result / verdict window
//  is_legal   out  1        1 = legal shapes; valid only with out_valid
//  change_row out  1        result is last column of a C row; only with out_valid
// BEHAVIOUR
//  Reset: all outputs 0, state LOAD_A, all counters and shapes 0.
//   - Reset mid-operation aborts immediately. The next load starts at wr_addr 0.
//  LOAD_A (busy=0): each beat writes wr_sel=0, wr_addr=cnt, then cnt++.
//   - First col_end sets a_cols = col+1. The col counter clears on every col_end.
//   - row_end sets a_rows = rows+1, clears cnt and goes to LOAD_B.
//  LOAD_B: same rules with wr_sel=1 and b_rows/b_cols. row_end goes to CHECK; busy=1 from the next cycle.
//  CHECK (1 cycle): a_cols!=b_rows goes to ILLEGAL; otherwise goes to COMPUTE with i=j=k=0.
//  ILLEGAL: out_valid=1, is_legal=0, change_row=0 for exactly 2 cycles.
//   - Then 1 gap cycle, then LOAD_A. No mac_* or res_load pulse is issued.
//  COMPUTE: one rd_addr pair per cycle for k=0..a_cols-1. Addresses come from running adders, no multipliers:
//   - A: a_base + k. a_base += a_cols per i.
//   - B: starts at j and adds b_cols per k.
//  MAC timing: mac_en/mac_clr/mac_last are the issue-cycle flags delayed by MAC_LAT.
//   - mac_clr marks k=0 and mac_last marks k=a_cols-1; both in the same cycle when a_cols=1.
//  WAIT: res_load pulses 1 cycle after the delayed mac_last, then PRESENT.
//  PRESENT: out_valid=1, is_legal=1 for exactly 2 cycles; change_row = (j==b_cols-1).
//   - The output register is stable until the next res_load.
//  GAP (1 cycle, out_valid=0):
//   - Advance j, wrapping to 0 and incrementing i.
//   - Return to COMPUTE, or, after i=a_rows-1 and j=b_cols-1, to LOAD_A (busy=0 the next cycle).
//  Beats during busy=1 are dropped. col_end/row_end without in_valid are ignored.
// CONFIGURATION
//  MM_SEQ_SHAPE_CHK_EN defined:
//   - Every col_end must occur at col==cols-1 of the first row.
//   - cnt must not exceed 2**ADDR_W-1; an out-of-range beat asserts no wr_en.
//   - Any violation latches a flag; CHECK then goes to ILLEGAL.
//  Undefined: only the first-row col_end is used; later col_end positions are ignored. Overflow wraps.
// STRUCTURE
//  mm_pkg: state enum (LOAD_A, LOAD_B, CHECK, ILLEGAL, COMPUTE, WAIT, PRESENT, GAP), DIM_W/ADDR_W defaults, OUT_HOLD=2, OUT_GAP=1.
//  Sub-module mm_seq_addr_gen: i/j/k counters, running bases, rd_addr_a/b and the issue flags.
// TESTING
//  1 rst high 3 cycles -> every output 0, busy=0; first beat after release -> wr_en=1, wr_sel=0, wr_addr=0.
//  2 A 2x3 (col_end beats 2,5; row_end 5), B 3x2 (col_end 1,3,5; row_end 5) -> busy=1 the cycle after B row_end.
//     - (0,0) reads A 0,1,2 / B 0,2,4; (0,1) reads A 0,1,2 / B 1,3,5.
//     - 4 PRESENT windows; change_row=1 on results 1 and 3.
//  3 A 2x3 then B 2x2 -> one 2-cycle out_valid with is_legal=0, mac_en never 1, busy=0 after the gap.
//  4 A 1x1, B 1x1 -> mac_clr=mac_last=1 in the same cycle; one result with change_row=1; then LOAD_A.
//  5 rst pulse during COMPUTE of test 2 -> busy and out_valid 0 immediately; reload 1x1*1x1 runs normally.
//  6 A beats with col_end at 2 then 4, row_end 5 -> with MM_SEQ_SHAPE_CHK_EN: is_legal=0; without: a_cols=3, a_rows=2.

Source files
------------

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared states and constants for the matrix-multiply sequencer
package mm_pkg;
    localparam int DIM_W_DEF  = 4;
    localparam int ADDR_W_DEF = 8;
    localparam int OUT_HOLD   = 2;
    localparam int OUT_GAP    = 1;

    typedef enum logic [2:0] {
        LOAD_A, LOAD_B, CHECK, ILLEGAL, COMPUTE, WAIT, PRESENT, GAP
    } mm_state_e;
endpackage

// File: rtl/mm_seq_ctrl_if.sv
// rtl/mm_seq_ctrl_if.sv - stream, buffer, MAC and result signals of the sequencer
interface mm_seq_ctrl_if
    import mm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic              in_valid;
    logic              col_end;
    logic              row_end;
    logic              busy;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              mac_clr;
    logic              mac_en;
    logic              mac_last;
    logic              res_load;
    logic              out_valid;
    logic              is_legal;
    logic              change_row;

    modport master (
        output in_valid, col_end, row_end,
        input  busy, wr_en, wr_sel, wr_addr, rd_addr_a, rd_addr_b,
        input  mac_clr, mac_en, mac_last, res_load, out_valid, is_legal, change_row
    );

    modport slave (
        input  in_valid, col_end, row_end,
        output busy, wr_en, wr_sel, wr_addr, rd_addr_a, rd_addr_b,
        output mac_clr, mac_en, mac_last, res_load, out_valid, is_legal, change_row
    );
endinterface

// File: rtl/mm_seq_addr_gen.sv
// rtl/mm_seq_addr_gen.sv - i/j/k counters and running-adder operand addresses
module mm_seq_addr_gen
    import mm_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              issue_i,
    input  logic              advance_i,
    input  logic [DIM_W-1:0]  a_rows_i,
    input  logic [DIM_W-1:0]  a_cols_i,
    input  logic [DIM_W-1:0]  b_cols_i,
    output logic [ADDR_W-1:0] rd_addr_a_o,
    output logic [ADDR_W-1:0] rd_addr_b_o,
    output logic              iss_en_o,
    output logic              iss_clr_o,
    output logic              iss_last_o,
    output logic              last_i_o,
    output logic              last_j_o
);
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d, b_addr_q, b_addr_d;
    logic              k_last;

    assign k_last      = (k_q == a_cols_i - DIM_W'(1));
    assign last_i_o    = (i_q == a_rows_i - DIM_W'(1));
    assign last_j_o    = (j_q == b_cols_i - DIM_W'(1));
    assign rd_addr_a_o = a_base_q + ADDR_W'(k_q);
    assign rd_addr_b_o = b_addr_q;
    assign iss_en_o    = issue_i;
    assign iss_clr_o   = issue_i && (k_q == '0);
    assign iss_last_o  = issue_i && k_last;

    always_comb begin
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        a_base_d = a_base_q;
        b_addr_d = b_addr_q;
        if (start_i) begin
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            a_base_d = '0;
            b_addr_d = '0;
        end else if (issue_i) begin
            k_d      = k_last ? '0 : k_q + DIM_W'(1);
            b_addr_d = b_addr_q + ADDR_W'(b_cols_i);
        end else if (advance_i) begin
            k_d = '0;
            // B column restarts at the new j; A base steps one row only on j wrap
            if (last_j_o) begin
                j_d      = '0;
                i_d      = i_q + DIM_W'(1);
                a_base_d = a_base_q + ADDR_W'(a_cols_i);
                b_addr_d = '0;
            end else begin
                j_d      = j_q + DIM_W'(1);
                b_addr_d = ADDR_W'(j_q) + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            b_addr_q <= '0;
        end else begin
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            a_base_q <= a_base_d;
            b_addr_q <= b_addr_d;
        end
    end
endmodule

// File: rtl/mm_seq_ctrl.sv
// rtl/mm_seq_ctrl.sv - load/check/compute/present sequencer; MM_SEQ_SHAPE_CHK_EN enables strict shape and overflow checks
module mm_seq_ctrl
    import mm_pkg::*;
#(
    parameter int DIM_W   = DIM_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MAC_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mm_seq_ctrl_if.slave bus
);
    localparam logic [1:0] HOLD_LAST = 2'(OUT_HOLD - 1);
    localparam logic [1:0] ILL_LAST  = 2'(OUT_HOLD + OUT_GAP - 1);

    mm_state_e         state_q, state_d;
    logic [1:0]        hold_q, hold_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [DIM_W-1:0]  col_q, rows_q, cols_q;
    logic              seen_q;
    logic [DIM_W-1:0]  a_rows_q, a_cols_q, b_rows_q, b_cols_q;
    logic              last_seen_q;
    logic              loading, beat, wrap, write_ok, shape_bad;
    logic              start, advance;
    logic              iss_en, iss_clr, iss_last, last_i, last_j;
    logic [ADDR_W-1:0] rd_a, rd_b;
    logic              res_load, out_valid, is_legal, change_row;
    logic [2:0]        pipe_q [MAC_LAT];

    assign loading = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign beat    = bus.in_valid & loading;
    // After the first row the shape is known, so row boundaries come from the column count
    assign wrap    = seen_q ? (col_q == cols_q - DIM_W'(1)) : bus.col_end;

`ifdef MM_SEQ_SHAPE_CHK_EN
    logic err_q, full_q;
    assign write_ok  = ~full_q;
    assign shape_bad = err_q || (a_cols_q != b_rows_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            if (state_q == CHECK)
                err_q <= 1'b0;
            else if (beat && (full_q || (bus.col_end && seen_q && !wrap)))
                err_q <= 1'b1;
            if (beat)
                full_q <= bus.row_end ? 1'b0 : (full_q || (cnt_q == '1));
        end
    end
`else
    assign write_ok  = 1'b1;
    assign shape_bad = (a_cols_q != b_rows_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            col_q    <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            seen_q   <= 1'b0;
            a_rows_q <= '0;
            a_cols_q <= '0;
            b_rows_q <= '0;
            b_cols_q <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (bus.row_end) begin
                cnt_q  <= '0;
                col_q  <= '0;
                rows_q <= '0;
                cols_q <= '0;
                seen_q <= 1'b0;
                if (state_q == LOAD_A) begin
                    a_rows_q <= rows_q + DIM_W'(1);
                    a_cols_q <= seen_q ? cols_q : col_q + DIM_W'(1);
                end else begin
                    b_rows_q <= rows_q + DIM_W'(1);
                    b_cols_q <= seen_q ? cols_q : col_q + DIM_W'(1);
                end
            end else if (wrap) begin
                col_q  <= '0;
                rows_q <= rows_q + DIM_W'(1);
                if (!seen_q) begin
                    cols_q <= col_q + DIM_W'(1);
                    seen_q <= 1'b1;
                end
            end else if (bus.col_end) begin
                col_q <= '0;
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end

    mm_seq_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .issue_i    (state_q == COMPUTE),
        .advance_i  (advance),
        .a_rows_i   (a_rows_q),
        .a_cols_i   (a_cols_q),
        .b_cols_i   (b_cols_q),
        .rd_addr_a_o(rd_a),
        .rd_addr_b_o(rd_b),
        .iss_en_o   (iss_en),
        .iss_clr_o  (iss_clr),
        .iss_last_o (iss_last),
        .last_i_o   (last_i),
        .last_j_o   (last_j)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        start      = 1'b0;
        advance    = 1'b0;
        res_load   = 1'b0;
        out_valid  = 1'b0;
        is_legal   = 1'b0;
        change_row = 1'b0;
        case (state_q)
            LOAD_A: if (beat && bus.row_end) state_d = LOAD_B;
            LOAD_B: if (beat && bus.row_end) state_d = CHECK;
            CHECK: begin
                hold_d = '0;
                if (shape_bad) begin
                    state_d = ILLEGAL;
                end else begin
                    state_d = COMPUTE;
                    start   = 1'b1;
                end
            end
            ILLEGAL: begin
                out_valid = (hold_q < 2'(OUT_HOLD));
                hold_d    = hold_q + 2'd1;
                if (hold_q == ILL_LAST) state_d = LOAD_A;
            end
            COMPUTE: if (iss_last) state_d = WAIT;
            WAIT: begin
                hold_d   = '0;
                res_load = last_seen_q;
                if (last_seen_q) state_d = PRESENT;
            end
            PRESENT: begin
                out_valid  = 1'b1;
                is_legal   = 1'b1;
                change_row = last_j;
                hold_d     = hold_q + 2'd1;
                if (hold_q == HOLD_LAST) state_d = GAP;
            end
            GAP: begin
                advance = 1'b1;
                state_d = (last_i && last_j) ? LOAD_A : COMPUTE;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD_A;
            hold_q      <= '0;
            last_seen_q <= 1'b0;
            for (int n = 0; n < MAC_LAT; n++) pipe_q[n] <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            last_seen_q <= bus.mac_last;
            pipe_q[0]   <= {iss_en, iss_clr, iss_last};
            for (int n = 1; n < MAC_LAT; n++) pipe_q[n] <= pipe_q[n-1];
        end
    end

    assign bus.busy       = ~loading;
    assign bus.wr_en      = beat & write_ok;
    assign bus.wr_sel     = (state_q == LOAD_B);
    assign bus.wr_addr    = cnt_q;
    assign bus.rd_addr_a  = rd_a;
    assign bus.rd_addr_b  = rd_b;
    assign {bus.mac_en, bus.mac_clr, bus.mac_last} = pipe_q[MAC_LAT-1];
    assign bus.res_load   = res_load;
    assign bus.out_valid  = out_valid;
    assign bus.is_legal   = is_legal;
    assign bus.change_row = change_row;
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb/tb_mm_seq_ctrl.sv - scoreboard bench for mm_seq_ctrl (honours MM_SEQ_SHAPE_CHK_EN)
module tb_mm_seq_ctrl;
    import mm_pkg::*;

    logic clk;
    logic rst;

    mm_seq_ctrl_if #(.ADDR_W(8)) bus ();

    mm_seq_ctrl #(.DIM_W(4), .ADDR_W(8), .MAC_LAT(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  wr_q  [$];
    logic [17:0] mac_q [$];
    logic [1:0]  out_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT output with empty expectation queue at %0t", name, $time);
    endtask

    task automatic beat(input logic sel, input int addr, input logic ce, input logic re);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.col_end  = ce;
        bus.row_end  = re;
        wr_q.push_back({sel, 8'(addr)});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.col_end  = 1'b0;
        bus.row_end  = 1'b0;
    endtask

    task automatic load(input logic sel, input int n, input logic [15:0] ce_mask);
        for (int idx = 0; idx < n; idx++) beat(sel, idx, ce_mask[idx], idx == n - 1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int cyc = 0;
        while (bus.busy && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(name, 32'(bus.busy), 32'(0));
    endtask

    task automatic check_drained(input string name);
        check({name, "_mac_left"}, 32'(mac_q.size()), 32'(0));
        check({name, "_out_left"}, 32'(out_q.size()), 32'(0));
    endtask

    // A 2x3 times B 3x2: A[i][k] at 3i+k, B[k][j] at 2k+j
    task automatic expect_2x3_3x2();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++)
                mac_q.push_back({8'((r / 2) * 3 + k), 8'((r % 2) + 2 * k), (k == 0), (k == 2)});
            out_q.push_back({1'b1, (r % 2 == 1)});
            out_q.push_back({1'b1, (r % 2 == 1)});
        end
    endtask

    task automatic run_1x1();
        mac_q.push_back({8'd0, 8'd0, 1'b1, 1'b1});
        out_q.push_back(2'b11);
        out_q.push_back(2'b11);
        load(1'b0, 1, 16'b1);
        load(1'b1, 1, 16'b1);
        idle();
        wait_idle("t1x1_done", 100);
    endtask

    initial begin
        logic [7:0]  pa;
        logic [7:0]  pb;
        logic [8:0]  ew;
        logic [17:0] em;
        logic [1:0]  eo;
        pa = '0;
        pb = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.wr_en) begin
                    if (wr_q.size() == 0) unexpected("wr");
                    else begin
                        ew = wr_q.pop_front();
                        check("wr_sel_addr", 32'({bus.wr_sel, bus.wr_addr}), 32'(ew));
                    end
                end
                if (bus.mac_en) begin
                    if (mac_q.size() == 0) unexpected("mac");
                    else begin
                        em = mac_q.pop_front();
                        check("mac_a_b_clr_last", 32'({pa, pb, bus.mac_clr, bus.mac_last}), 32'(em));
                    end
                end
                if (bus.out_valid) begin
                    if (out_q.size() == 0) unexpected("out");
                    else begin
                        eo = out_q.pop_front();
                        check("out_legal_chrow", 32'({bus.is_legal, bus.change_row}), 32'(eo));
                    end
                end
            end
            pa = bus.rd_addr_a;
            pb = bus.rd_addr_b;
        end
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.col_end  = 1'b0;
        bus.row_end  = 1'b0;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_wr", 32'({bus.wr_en, bus.wr_sel, bus.wr_addr}), 32'(0));
        check("rst_rd", 32'({bus.rd_addr_a, bus.rd_addr_b}), 32'(0));
        check("rst_ctl", 32'({bus.mac_clr, bus.mac_en, bus.mac_last, bus.res_load,
                              bus.out_valid, bus.is_legal, bus.change_row}), 32'(0));
        rst = 1'b0;

        // 2: legal 2x3 * 3x2, plus a beat dropped while busy
        expect_2x3_3x2();
        load(1'b0, 6, 16'b100100);
        load(1'b1, 6, 16'b101010);
        idle();
        check("t2_busy_after_b", 32'(bus.busy), 32'(1));
        bus.in_valid = 1'b1;
        bus.col_end  = 1'b1;
        bus.row_end  = 1'b1;
        #1;
        check("t2_drop_wr_en", 32'(bus.wr_en), 32'(0));
        idle();
        wait_idle("t2_done", 200);
        check_drained("t2");

        // 3: 2x3 * 2x2 is illegal
        out_q.push_back(2'b00);
        out_q.push_back(2'b00);
        load(1'b0, 6, 16'b100100);
        load(1'b1, 4, 16'b1010);
        idle();
        wait_idle("t3_done", 50);
        check_drained("t3");

        // 4: 1x1 * 1x1
        run_1x1();
        check_drained("t4");

        // 5: reset during compute, then a clean 1x1 run
        expect_2x3_3x2();
        load(1'b0, 6, 16'b100100);
        load(1'b1, 6, 16'b101010);
        idle();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 32'(0));
        check("t5_rst_out", 32'({bus.out_valid, bus.mac_en}), 32'(0));
        mac_q.delete();
        out_q.delete();
        wr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_1x1();
        check_drained("t5");

        // 6: A with a misplaced second col_end, B 3x1
`ifdef MM_SEQ_SHAPE_CHK_EN
        out_q.push_back(2'b00);
        out_q.push_back(2'b00);
`else
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++)
                mac_q.push_back({8'(i * 3 + k), 8'(k), (k == 0), (k == 2)});
            out_q.push_back(2'b11);
            out_q.push_back(2'b11);
        end
`endif
        load(1'b0, 6, 16'b110100);
        load(1'b1, 3, 16'b111);
        idle();
        wait_idle("t6_done", 100);
        check_drained("t6");
        check("wr_left", 32'(wr_q.size()), 32'(0));

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
